// File: rtl/spi_byte_parser.sv
// Decodes per-chip-select SPI command bytes into LED frame RAM writes and a config byte latch.
// Latency: RAM/config outputs 1 cycle after byte_rdy_in; frame_rdy_out 1 cycle after registered cs rise.
// Backpressure: none; every strobe is consumed, bytes beyond the frame or outside a command are dropped.
module spi_byte_parser #(
    parameter int LED_NUM = 64,
    parameter int ADDR_W  = 8
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              spi_cs_n_in,
    input  logic              byte_rdy_in,
    input  logic [7:0]        byte_data_in,
    output logic              ram_wr_en_out,
    output logic [ADDR_W-1:0] ram_wr_addr_out,
    output logic [7:0]        ram_wr_data_out,
    output logic              cfg_wr_out,
    output logic [7:0]        cfg_data_out,
    output logic              frame_rdy_out
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(3 * LED_NUM - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        CONF    = 3'd2,
        DATA    = 3'd3,
        DISCARD = 3'd4
    } state_t;

    state_t            state;
    logic              cs_meta;
    logic              cs_sync;
    logic              cs_sync_d;
    logic              cs_rise;
    logic [ADDR_W-1:0] wr_addr;
    logic              written;
    logic              full;
    logic              cs_active;
    logic              data_wr;

    assign cs_active = ~cs_sync;
    // A byte arriving together with cs_rise still counts towards the frame.
    assign data_wr   = (state == DATA) && byte_rdy_in && !full;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cs_meta   <= 1'b1;
            cs_sync   <= 1'b1;
            cs_sync_d <= 1'b1;
            cs_rise   <= 1'b0;
        end else begin
            cs_meta   <= spi_cs_n_in;
            cs_sync   <= cs_meta;
            cs_sync_d <= cs_sync;
            cs_rise   <= cs_sync & ~cs_sync_d;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state           <= IDLE;
            wr_addr         <= '0;
            written         <= 1'b0;
            full            <= 1'b0;
            ram_wr_en_out   <= 1'b0;
            ram_wr_addr_out <= '0;
            ram_wr_data_out <= 8'h00;
            cfg_wr_out      <= 1'b0;
            cfg_data_out    <= 8'h00;
            frame_rdy_out   <= 1'b0;
        end else begin
            ram_wr_en_out <= 1'b0;
            cfg_wr_out    <= 1'b0;
            frame_rdy_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (cs_active) state <= CMD;
                end
                CMD: begin
                    if (byte_rdy_in) begin
                        case (byte_data_in)
                            8'h2A: state <= CONF;
                            8'h2C: begin
                                state   <= DATA;
                                wr_addr <= '0;
                                written <= 1'b0;
                                full    <= 1'b0;
                            end
                            8'h00: state <= CMD;
                            default: state <= DISCARD;
                        endcase
                    end
                end
                CONF: begin
                    if (byte_rdy_in) begin
                        cfg_data_out <= byte_data_in;
                        cfg_wr_out   <= 1'b1;
                        state        <= DISCARD;
                    end
                end
                DATA: begin
                    if (data_wr) begin
                        ram_wr_en_out   <= 1'b1;
                        ram_wr_addr_out <= wr_addr;
                        ram_wr_data_out <= byte_data_in;
                        written         <= 1'b1;
                        // Saturate on the last frame byte so later bytes are dropped.
                        if (wr_addr == LAST_ADDR) full <= 1'b1;
                        else wr_addr <= wr_addr + ADDR_W'(1);
                    end
                end
                default: state <= DISCARD;
            endcase
            if (state != IDLE && cs_rise) begin
                state         <= IDLE;
                frame_rdy_out <= (state == DATA) && (written || data_wr);
            end
        end
    end

endmodule

// File: tb/tb_spi_byte_parser.sv
// Directed and randomized command transactions checked against a list-based model of the parser.
module tb_spi_byte_parser;
    localparam int LED_NUM = 2;
    localparam int ADDR_W  = 8;
    localparam int FRAME   = 3 * LED_NUM;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              spi_cs_n_in;
    logic              byte_rdy_in;
    logic [7:0]        byte_data_in;
    logic              ram_wr_en_out;
    logic [ADDR_W-1:0] ram_wr_addr_out;
    logic [7:0]        ram_wr_data_out;
    logic              cfg_wr_out;
    logic [7:0]        cfg_data_out;
    logic              frame_rdy_out;

    spi_byte_parser #(.LED_NUM(LED_NUM), .ADDR_W(ADDR_W)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .spi_cs_n_in     (spi_cs_n_in),
        .byte_rdy_in     (byte_rdy_in),
        .byte_data_in    (byte_data_in),
        .ram_wr_en_out   (ram_wr_en_out),
        .ram_wr_addr_out (ram_wr_addr_out),
        .ram_wr_data_out (ram_wr_data_out),
        .cfg_wr_out      (cfg_wr_out),
        .cfg_data_out    (cfg_data_out),
        .frame_rdy_out   (frame_rdy_out)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int cfg_cnt = 0;
    int frame_cnt = 0;

    logic [7:0] tx[$];
    bit         m_wr[64];
    int         m_addr[64];
    bit         m_cfg[64];
    logic [7:0] model_cfg = 8'h00;

    always @(negedge clk_in) begin
        if (ram_wr_en_out) wr_cnt++;
        if (cfg_wr_out) cfg_cnt++;
        if (frame_rdy_out) frame_cnt++;
    end

    task automatic step();
        @(negedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_byte(input int i);
        check("wr_en", 32'(ram_wr_en_out), 32'(m_wr[i]));
        if (m_wr[i]) begin
            check("wr_addr", 32'(ram_wr_addr_out), 32'(m_addr[i]));
            check("wr_data", 32'(ram_wr_data_out), 32'(tx[i]));
        end
        check("cfg_wr", 32'(cfg_wr_out), 32'(m_cfg[i]));
        if (m_cfg[i]) check("cfg_data", 32'(cfg_data_out), 32'(tx[i]));
    endtask

    // One chip-select transaction of tx; with overlap the last byte meets the registered cs rise.
    task automatic run_txn(input bit overlap);
        int  n;
        int  k;
        int  nb;
        int  n_wr;
        int  n_cfg;
        bit  exp_frame;
        int  wr0;
        int  cfg0;
        int  fr0;
        n = tx.size();
        n_wr = 0;
        n_cfg = 0;
        exp_frame = 1'b0;
        for (int i = 0; i < 64; i++) begin
            m_wr[i] = 1'b0;
            m_addr[i] = 0;
            m_cfg[i] = 1'b0;
        end
        k = 0;
        while (k < n && tx[k] == 8'h00) k++;
        if (k < n && tx[k] == 8'h2C) begin
            for (int j = k + 1; j < n; j++) begin
                if (j - k - 1 < FRAME) begin
                    m_wr[j] = 1'b1;
                    m_addr[j] = j - k - 1;
                    n_wr++;
                    exp_frame = 1'b1;
                end
            end
        end
        if (k + 1 < n && tx[k] == 8'h2A) begin
            m_cfg[k+1] = 1'b1;
            n_cfg = 1;
            model_cfg = tx[k+1];
        end
        wr0 = wr_cnt;
        cfg0 = cfg_cnt;
        fr0 = frame_cnt;
        nb = (overlap && n > 0) ? n - 1 : n;

        spi_cs_n_in = 1'b0;
        repeat (3) step();
        for (int i = 0; i < nb; i++) begin
            byte_rdy_in = 1'b1;
            byte_data_in = tx[i];
            step();
            check_byte(i);
            byte_rdy_in = 1'b0;
            repeat ($urandom_range(0, 2)) step();
        end
        spi_cs_n_in = 1'b1;
        repeat (3) step();
        if (nb < n) begin
            byte_rdy_in = 1'b1;
            byte_data_in = tx[n-1];
            step();
            byte_rdy_in = 1'b0;
            check_byte(n - 1);
        end else begin
            step();
        end
        check("frame_rdy_at_4", 32'(frame_rdy_out), 32'(exp_frame));
        repeat (3) step();
        check("wr_count", 32'(wr_cnt - wr0), 32'(n_wr));
        check("cfg_count", 32'(cfg_cnt - cfg0), 32'(n_cfg));
        check("frame_count", 32'(frame_cnt - fr0), 32'(exp_frame ? 1 : 0));
        check("cfg_hold", 32'(cfg_data_out), 32'(model_cfg));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"}, 32'(ram_wr_en_out), 32'd0);
        check({tag, "_wr_addr"}, 32'(ram_wr_addr_out), 32'd0);
        check({tag, "_wr_data"}, 32'(ram_wr_data_out), 32'd0);
        check({tag, "_cfg_wr"}, 32'(cfg_wr_out), 32'd0);
        check({tag, "_cfg_data"}, 32'(cfg_data_out), 32'd0);
        check({tag, "_frame"}, 32'(frame_rdy_out), 32'd0);
    endtask

    initial begin
        int fr0;
        int n;
        int pick;
        rst_in = 1'b1;
        spi_cs_n_in = 1'b1;
        byte_rdy_in = 1'b0;
        byte_data_in = 8'h00;
        repeat (2) step();
        check_all_zero("reset");
        rst_in = 1'b0;
        step();

        tx = '{8'h2C, 8'h11, 8'h22, 8'h33};
        run_txn(1'b0);
        tx = '{8'h2C, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        run_txn(1'b0);
        check("overflow_addr_hold", 32'(ram_wr_addr_out), 32'd5);
        tx = '{8'h2A, 8'h5A, 8'h77};
        run_txn(1'b0);
        tx = '{8'h00, 8'h2C, 8'hAB};
        run_txn(1'b0);
        tx = '{8'h99, 8'h2C, 8'hAB};
        run_txn(1'b0);
        tx = '{8'h2C, 8'h11, 8'h22};
        run_txn(1'b1);
        tx = '{8'h2C};
        run_txn(1'b0);
        tx = {};
        run_txn(1'b0);

        // Reset in the middle of a data frame.
        fr0 = frame_cnt;
        spi_cs_n_in = 1'b0;
        repeat (3) step();
        byte_rdy_in = 1'b1;
        byte_data_in = 8'h2C;
        step();
        byte_data_in = 8'h10;
        step();
        byte_data_in = 8'h20;
        step();
        byte_rdy_in = 1'b0;
        rst_in = 1'b1;
        #1;
        check_all_zero("midreset");
        spi_cs_n_in = 1'b1;
        repeat (3) step();
        rst_in = 1'b0;
        model_cfg = 8'h00;
        repeat (6) step();
        check("midreset_no_frame", 32'(frame_cnt - fr0), 32'd0);
        check_all_zero("after_reset");

        for (int t = 0; t < 40; t++) begin
            n = $urandom_range(0, 10);
            tx = {};
            for (int i = 0; i < n; i++) begin
                pick = $urandom_range(0, 3);
                if (i == 0)
                    tx.push_back(pick == 0 ? 8'h00 : pick == 1 ? 8'h2A :
                                 pick == 2 ? 8'h2C : 8'($urandom));
                else
                    tx.push_back(pick == 0 ? 8'h00 : 8'($urandom));
            end
            run_txn(1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_byte_parser.md
# spi_byte_parser

Command parser sitting directly downstream of the SPI slave byte deserializer in the NeoPixel LED controller. Consumes the one-cycle byte-ready strobe and byte value, decodes a leading command byte per chip-select transaction, writes pixel bytes into the LED frame RAM with an auto-incrementing address, latches a configuration byte, and signals frame completion to the LED output stage.

## Interface
- LED_NUM, 64: number of LEDs; frame size is 3*LED_NUM bytes (GRB).
- ADDR_W, 8: RAM address width; 3*LED_NUM <= 2**ADDR_W required.

- clk_in  input  1  system clock; all logic on rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- spi_cs_n_in  input  1  raw SPI chip select, asynchronous to clk_in.
- byte_rdy_in  input  1  one-cycle strobe, byte_data_in valid.
- byte_data_in  input  8  received byte.
- ram_wr_en_out  output  1  one-cycle RAM write strobe.
- ram_wr_addr_out  output  ADDR_W  RAM write address.
- ram_wr_data_out  output  8  RAM write data.
- cfg_wr_out  output  1  one-cycle pulse, cfg_data_out updated.
- cfg_data_out  output  8  latched configuration byte.
- frame_rdy_out  output  1  one-cycle pulse, frame data written.

## Operation
- spi_cs_n_in passed through a 2-flop synchronizer (reset value 1); cs_active = synchronized value low; cs_rise = registered rising edge of synchronized value.
- States: IDLE, CMD, CONF, DATA, DISCARD.
- IDLE: wait for cs_active -> CMD. Bytes in IDLE ignored.
- CMD: first byte_rdy_in decodes command:
  - 0x2A -> CONF.
  - 0x2C -> DATA; write address counter cleared to 0, written flag cleared.
  - 0x00 -> stays CMD (NOP, next byte re-decoded).
  - any other -> DISCARD.
- CONF: next byte latched into cfg_data_out, cfg_wr_out pulsed, -> DISCARD (further bytes ignored).
- DATA: each byte -> ram_wr_en_out pulse with current address and data; address increments by 1; written flag set. When address == 3*LED_NUM-1 is written, counter saturates and further bytes are dropped (no write strobe), state stays DATA.
- Any state except IDLE: cs_rise -> IDLE. If leaving DATA with written flag set, frame_rdy_out pulses once.
- Simultaneous byte_rdy_in and cs_rise: byte is processed under current state first (write/latch occurs), then state goes IDLE; frame_rdy_out accounts for that byte.
- Arithmetic: address counter ADDR_W bits, never wraps; compare against 3*LED_NUM-1 as a constant.

## Timing
- Reset values: ram_wr_en_out 0, ram_wr_addr_out 0, ram_wr_data_out 0, cfg_wr_out 0, cfg_data_out 0, frame_rdy_out 0, state IDLE, address counter 0.
- All outputs registered. RAM write strobe/addr/data and cfg_wr_out/cfg_data_out valid 1 cycle after byte_rdy_in.
- cs assertion visible to FSM 2 cycles after spi_cs_n_in falls; cs_rise asserted 3 cycles after spi_cs_n_in rises; frame_rdy_out 1 cycle after cs_rise.
- Back-to-back byte_rdy_in on consecutive cycles supported (one write per strobe).
- Reset mid-transaction: all state cleared immediately; no frame_rdy_out; cfg_data_out returns to 0.
- cs deasserting before any byte: IDLE, no pulses.

## Test plan
- Reset: assert rst_in mid-DATA -> all outputs 0, state IDLE, no frame_rdy_out on release.
- Data frame: CS low, bytes 0x2C,0x11,0x22,0x33, CS high -> writes addr0=0x11, addr1=0x22, addr2=0x33, each 1 cycle after strobe; one frame_rdy_out pulse 4 cycles after CS rise.
- Overflow: LED_NUM=2, 0x2C then 8 bytes 0x01..0x08 -> 6 writes addr0..5 data 0x01..0x06; bytes 0x07,0x08 produce no strobe; addr stays 5; one frame_rdy_out.
- Config: 0x2A,0x5A,0x77 -> cfg_data_out=0x5A with one cfg_wr_out pulse; 0x77 ignored; no frame_rdy_out.
- Unknown/NOP: 0x00,0x2C,0xAB -> write addr0=0xAB; separate transaction 0x99,0x2C,0xAB -> no writes, no pulses.
- Edge overlap: last data byte strobe coincident with cs_rise -> byte written, frame_rdy_out pulses next cycle; 0x2C alone then CS high -> no frame_rdy_out.
